clock_works: RTL and testbench
==============================

CLOCK_WORKS -- requirements
Module: clock_works

Interface
- REQ-001 SHALL have parameter SLOW, default 22: divide exponent, legal 0..30; slow clock period = 2^SLOW clk cycles.
- REQ-002 SHALL have parameter RST_CYCLES, default 16: slow-clock periods resetn_out is held low after reset release; legal 1..255.
- REQ-003 SHALL have port clk, input, 1 bit: board clock (25 MHz); the only clock.
- REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low; clock clk.
- REQ-005 SHALL have port clk_out, output, 1 bit: divided clock for downstream logic.
- REQ-006 SHALL have port resetn_out, output, 1 bit: active-low reset for the clk_out domain.
- REQ-007 SHALL have port tick, output, 1 bit: one-clk-cycle pulse marking each slow period.

Function
- REQ-008 For SLOW≥1, the block SHALL contain an SLOW-bit counter div that increments by 1 on every clk rising edge and wraps from all-ones to 0.
- REQ-009 For SLOW≥1, clk_out SHALL equal div[SLOW-1], with duty cycle 50 % and period 2^SLOW clk cycles.
- REQ-010 For SLOW≥1, the first clk_out rising edge after reset release SHALL occur at the 2^(SLOW-1)-th clk edge after release.
- REQ-011 For SLOW=0, clk_out SHALL be clk passed through combinationally, and tick SHALL be constant 1.
- REQ-012 For SLOW≥1, tick SHALL be 1 exactly when div == 2^(SLOW-1), i.e. during the first clk cycle of each clk_out high phase, and 0 otherwise.
- REQ-013 An 8-bit counter rcnt SHALL increment, saturating at RST_CYCLES, at each clk edge where div wraps to 0 (every clk edge when SLOW=0).
- REQ-014 resetn_out SHALL be a register set to 1 at the clk edge where rcnt reaches RST_CYCLES, and SHALL stay 1 until the next reset.
- REQ-015 resetn_out SHALL change only coincident with clk_out falling, i.e. never on a clk_out rising edge.
- REQ-016 Simultaneous wrap and resetn low: reset SHALL take priority; no count SHALL occur.
- REQ-017 Counters SHALL never overflow; rcnt SHALL hold at RST_CYCLES indefinitely.

Reset
- REQ-018 While resetn=0 at a clk edge, div, rcnt and resetn_out SHALL be cleared to 0; hence clk_out=0 and tick=0 (SLOW≥1).
- REQ-019 Reset asserted mid-operation SHALL take effect at the next clk edge, and the full stretch sequence SHALL restart after release.
- REQ-020 Power-up initial values SHALL be div=0, rcnt=0 and resetn_out=0, so downstream logic starts in reset even without a resetn pulse.

Structure
- REQ-021 No shared package SHALL be used; widths SHALL be derived locally from the parameters.
- REQ-022 One sub-module SHALL be acceptable: clock_works_divider, containing div, clk_out and tick; the reset stretcher SHALL stay in the top module.
- REQ-023 No gated or derived clocks SHALL be used other than clk_out itself; all registers SHALL be clocked by clk.

Verification (SLOW=3, RST_CYCLES=2 unless noted)
- REQ-024 Reset: hold resetn=0 for 5 cycles -> clk_out=0, tick=0, resetn_out=0 throughout.
- REQ-025 Division: release resetn -> clk_out rises at edge 4 and falls at edge 8, then repeats with period 8; tick is high only in cycles where div=4.
- REQ-026 Stretch: after release, resetn_out stays 0 through edge 15, becomes 1 at edge 16, and remains 1 for 100 cycles.
- REQ-027 Mid-operation reset: drive resetn=0 at edge 11 for 1 cycle -> clk_out=0 and resetn_out=0 next edge; after release, the REQ-025/026 timing repeats exactly.
- REQ-028 SLOW=0, RST_CYCLES=2: clk_out tracks clk; tick=1; resetn_out becomes 1 at the 2nd clk edge after release.
- REQ-029 Default parameters: count 2^22 cycles -> exactly one clk_out period and one tick pulse.

Source files
------------

// File: rtl/clock_works_divider.sv
// clock_works_divider
// Free-running power-of-two divider for the board clock.
// With SLOW >= 1 it holds an SLOW-bit counter div that advances on every clk
// edge. clk_out is the counter MSB (50 % duty cycle, period 2^SLOW).
// With SLOW = 0 the board clock is passed straight through.
//
// Ports
//   clk     in   board clock, the only clock
//   resetn  in   synchronous active-low reset (clears div)
//   clk_out out  divided clock (div MSB, or clk itself when SLOW = 0)
//   tick    out  high for the first clk cycle of each clk_out high phase
//   wrap    out  high when div is all-ones, so it returns to 0 on this edge
module clock_works_divider #(
  parameter int SLOW = 22
) (
  input  logic clk,
  input  logic resetn,
  output logic clk_out,
  output logic tick,
  output logic wrap
);

  generate
    if (SLOW == 0) begin : g_bypass
      // Without a divider every edge counts as a wrap and every cycle is a tick.
      assign clk_out = clk;
      assign tick    = 1'b1;
      assign wrap    = 1'b1;
    end else begin : g_div
      localparam logic [SLOW-1:0] HALF = SLOW'(1) << (SLOW - 1);

      // The initial value is the power-up state when no resetn pulse arrives.
      logic [SLOW-1:0] r_div = '0;

      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_div <= '0;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      assign clk_out = r_div[SLOW-1];
      assign tick    = (r_div == HALF);
      assign wrap    = &r_div;
    end
  endgenerate

endmodule

// File: rtl/clock_works.sv
// clock_works
// Board clock divider plus a reset stretcher for the divided domain.
// resetn_out is held low for RST_CYCLES full slow-clock periods after resetn
// is released. It only rises on the clk edge where div wraps, and that edge
// is a clk_out falling edge, so the slow domain never sees its reset release
// on a rising edge.
//
// Parameters
//   SLOW        divide exponent (0..30); slow period = 2^SLOW clk cycles
//   RST_CYCLES  slow periods resetn_out stays low after release (1..255)
//
// Ports
//   clk         in   board clock (25 MHz), the only clock
//   resetn      in   synchronous active-low reset
//   clk_out     out  divided clock
//   resetn_out  out  active-low reset for the clk_out domain
//   tick        out  one-clk pulse per slow period
module clock_works #(
  parameter int SLOW       = 22,
  parameter int RST_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  output logic clk_out,
  output logic resetn_out,
  output logic tick
);

  localparam logic [7:0] RST_CNT = 8'(RST_CYCLES);

  logic       w_wrap;
  // The initial values put the downstream logic in reset at power-up.
  logic [7:0] r_rcnt       = 8'd0;
  logic       r_resetn_out = 1'b0;

  clock_works_divider #(
    .SLOW (SLOW)
  ) u_div (
    .clk     (clk),
    .resetn  (resetn),
    .clk_out (clk_out),
    .tick    (tick),
    .wrap    (w_wrap)
  );

  // Reset wins over a coincident wrap. rcnt saturates at RST_CNT, and
  // resetn_out rises on the same edge that rcnt reaches RST_CNT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rcnt       <= 8'd0;
      r_resetn_out <= 1'b0;
    end else if (w_wrap && (r_rcnt != RST_CNT)) begin
      r_rcnt <= r_rcnt + 8'd1;
      if ((r_rcnt + 8'd1) == RST_CNT) begin
        r_resetn_out <= 1'b1;
      end
    end
  end

  assign resetn_out = r_resetn_out;

endmodule

// File: tb/tb_clock_works.sv
module tb_clock_works;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic clk_out, resetn_out, tick;
  logic clk_out0, resetn_out0, tick0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clock_works #(.SLOW(3), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clk_out    (clk_out),
    .resetn_out (resetn_out),
    .tick       (tick)
  );

  clock_works #(.SLOW(0), .RST_CYCLES(2)) dut0 (
    .clk        (clk),
    .resetn     (resetn),
    .clk_out    (clk_out0),
    .resetn_out (resetn_out0),
    .tick       (tick0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Run k = 1..n edges after a release and compare against the expected
  // timing: SLOW=3 gives clk_out high for k mod 8 in 4..7, tick at k mod 8 = 4,
  // and resetn_out high from edge 16 on. SLOW=0 gives resetn_out high from edge 2.
  task automatic run_after_release(input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      edge_sample();
      chk({tag, " clk_out"},    clk_out,    ((k % 8) >= 4) ? 1 : 0);
      chk({tag, " tick"},       tick,       ((k % 8) == 4) ? 1 : 0);
      chk({tag, " resetn_out"}, resetn_out, (k >= 16) ? 1 : 0);
      chk({tag, " s0 clk_out hi"}, clk_out0, 1);
      chk({tag, " s0 tick"},       tick0,    1);
      chk({tag, " s0 resetn_out"}, resetn_out0, (k >= 2) ? 1 : 0);
      if (k <= 4) begin
        @(negedge clk);
        #1;
        chk({tag, " s0 clk_out lo"}, clk_out0, 0);
      end
    end
  endtask

  initial begin
    #1;
    chk("powerup resetn_out",    resetn_out,  0);
    chk("powerup clk_out",       clk_out,     0);
    chk("powerup s0 resetn_out", resetn_out0, 0);

    resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_sample();
      chk("rst clk_out",       clk_out,     0);
      chk("rst tick",          tick,        0);
      chk("rst resetn_out",    resetn_out,  0);
      chk("rst s0 resetn_out", resetn_out0, 0);
      chk("rst s0 tick",       tick0,       1);
    end

    resetn = 1'b1;
    run_after_release(120, "run1");
    chk("rcnt saturated", dut.r_rcnt, 2);
    chk("s0 rcnt saturated", dut0.r_rcnt, 2);

    // Reset while resetn_out is already high.
    resetn = 1'b0;
    edge_sample();
    chk("late rst clk_out",       clk_out,     0);
    chk("late rst tick",          tick,        0);
    chk("late rst resetn_out",    resetn_out,  0);
    chk("late rst s0 resetn_out", resetn_out0, 0);
    chk("late rst rcnt",          dut.r_rcnt,  0);
    resetn = 1'b1;
    run_after_release(40, "run2");

    // Reset after a clean release, landing on edge 11.
    resetn = 1'b0;
    edge_sample();
    resetn = 1'b1;
    run_after_release(10, "run3");
    resetn = 1'b0;
    edge_sample();
    chk("mid rst clk_out",    clk_out,    0);
    chk("mid rst tick",       tick,       0);
    chk("mid rst resetn_out", resetn_out, 0);
    resetn = 1'b1;
    run_after_release(40, "run4");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
